// File: rtl/ah_pkt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ah_pkt_pkg
// Purpose  : Shared widths, credit constants and count-width helper for the
//            ah packet converters (w2n / n2w).
// Revision : 1.0
// ============================================================================
package ah_pkt_pkg;

    localparam int AH_WIDE_W      = 32;
    localparam int AH_NARROW_W    = 20;
    localparam int AH_IN_DEPTH    = 2;
    localparam int AH_OUT_CREDITS = 4;

    // Bits needed to hold any value in 0..max_val, never less than one.
    function automatic int ah_cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    localparam int AH_CCNT_W = ah_cnt_w(AH_OUT_CREDITS);
    localparam int AH_ICNT_W = ah_cnt_w(AH_IN_DEPTH);

endpackage
`default_nettype wire

// File: rtl/ah_credit_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ah_credit_fifo
// Purpose  : Synchronous FIFO with a registered credit-return pulse per pop.
// Revision : 1.0
// ============================================================================
module ah_credit_fifo
    import ah_pkt_pkg::*;
#(
    parameter int WIDTH = AH_WIDE_W,
    parameter int DEPTH = AH_IN_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_credit
);

    localparam int C_PTR_W = (DEPTH < 2) ? 1 : $clog2(DEPTH);
    localparam int C_CNT_W = ah_cnt_w(DEPTH);
    localparam logic [C_PTR_W-1:0] C_PTR_LAST = C_PTR_W'(DEPTH - 1);
    localparam logic [C_CNT_W-1:0] C_CNT_FULL = C_CNT_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [C_PTR_W-1:0] r_wptr;
    logic [C_PTR_W-1:0] r_rptr;
    logic [C_CNT_W-1:0] r_count;
    logic               r_credit;
    logic               w_push_ok;
    logic               w_pop_ok;

    assign o_full     = (r_count == C_CNT_FULL);
    assign o_empty    = (r_count == '0);
    assign o_pop_data = r_mem[r_rptr];
    assign o_credit   = r_credit;

    // A push into a full FIFO is dropped; state stays untouched.
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_credit <= 1'b0;
        end else begin
            r_credit <= w_pop_ok;
            if (w_push_ok) begin
                r_wptr <= (r_wptr == C_PTR_LAST) ? '0 : r_wptr + C_PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rptr <= (r_rptr == C_PTR_LAST) ? '0 : r_rptr + C_PTR_W'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + C_CNT_W'(1);
                2'b01:   r_count <= r_count - C_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push_ok) begin
            r_mem[r_wptr] <= i_push_data;
        end
    end

    a_no_push_when_full : assert property (@(posedge clk) disable iff (rst) !(i_push && o_full));

endmodule
`default_nettype wire

// File: rtl/ah_packet_converter_w2n.sv
`default_nettype none
// ============================================================================
// Module   : ah_packet_converter_w2n
// Purpose  : Wide-to-narrow credit-based stream gearbox, LSB-first.
// Revision : 1.0
// ============================================================================
module ah_packet_converter_w2n
    import ah_pkt_pkg::*;
#(
    parameter int WIDE_W      = AH_WIDE_W,
    parameter int NARROW_W    = AH_NARROW_W,
    parameter int IN_DEPTH    = AH_IN_DEPTH,
    parameter int OUT_CREDITS = AH_OUT_CREDITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WIDE_W-1:0]   rdata,
    input  logic                rvalid,
    output logic                rcredit,
    output logic [NARROW_W-1:0] wdata,
    output logic                wvalid,
    input  logic                wcredit
);

    localparam int C_ACC_W  = NARROW_W + WIDE_W - 1;
    localparam int C_CNT_W  = ah_cnt_w(C_ACC_W);
    localparam int C_CCNT_W = ah_cnt_w(OUT_CREDITS);
    localparam logic [C_CNT_W-1:0]  C_NARROW = C_CNT_W'(NARROW_W);
    localparam logic [C_CNT_W-1:0]  C_WIDE   = C_CNT_W'(WIDE_W);
    localparam logic [C_CCNT_W-1:0] C_CRED   = C_CCNT_W'(OUT_CREDITS);

    logic [C_ACC_W-1:0]  r_acc;
    logic [C_CNT_W-1:0]  r_cnt;
    logic [C_CCNT_W-1:0] r_ccnt;
    logic [NARROW_W-1:0] r_wdata;
    logic                r_wvalid;

    logic [C_ACC_W-1:0]  w_acc_ae;
    logic [C_ACC_W-1:0]  w_acc_nxt;
    logic [C_ACC_W-1:0]  w_load_bits;
    logic [C_CNT_W-1:0]  w_cnt_ae;
    logic [C_CNT_W-1:0]  w_cnt_nxt;
    logic [WIDE_W-1:0]   w_head;
    logic                w_full;
    logic                w_empty;
    logic                w_emit;
    logic                w_load;

    ah_credit_fifo #(
        .WIDTH (WIDE_W),
        .DEPTH (IN_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (rvalid),
        .i_push_data (rdata),
        .i_pop       (w_load),
        .o_pop_data  (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_credit    (rcredit)
    );

    // Emit first, then load at the post-emit fill level so both can share a cycle.
    always_comb begin
        w_emit    = (r_cnt >= C_NARROW) && (r_ccnt != '0);
        w_cnt_ae  = r_cnt;
        w_acc_ae  = r_acc;
        if (w_emit) begin
            w_cnt_ae = r_cnt - C_NARROW;
            w_acc_ae = r_acc >> NARROW_W;
        end
        w_load      = !w_empty && (w_cnt_ae < C_NARROW);
        w_load_bits = C_ACC_W'(w_head) << w_cnt_ae;
        w_acc_nxt   = w_acc_ae;
        w_cnt_nxt   = w_cnt_ae;
        if (w_load) begin
            w_acc_nxt = w_acc_ae | w_load_bits;
            w_cnt_nxt = w_cnt_ae + C_WIDE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_ccnt   <= C_CRED;
            r_wdata  <= '0;
            r_wvalid <= 1'b0;
        end else begin
            r_acc    <= w_acc_nxt;
            r_cnt    <= w_cnt_nxt;
            r_wvalid <= w_emit;
            if (w_emit) begin
                r_wdata <= r_acc[NARROW_W-1:0];
            end
            // A surplus credit at the ceiling is ignored rather than wrapping.
            if (w_emit && !wcredit) begin
                r_ccnt <= r_ccnt - C_CCNT_W'(1);
            end else if (!w_emit && wcredit && (r_ccnt != C_CRED)) begin
                r_ccnt <= r_ccnt + C_CCNT_W'(1);
            end
        end
    end

    assign wdata  = r_wdata;
    assign wvalid = r_wvalid;

    a_no_credit_overflow : assert property (@(posedge clk) disable iff (rst)
        !(wcredit && !w_emit && (r_ccnt == C_CRED)));

endmodule
`default_nettype wire
